// File: rtl/mnet_pkg.sv
// Shared sizes, score type and FSM state encoding for the mini-MobileNet loader.
package mnet_pkg;

    localparam int INPUT_SIZE      = 32;
    localparam int INPUT_CHANNELS  = 1;
    localparam int PX_SIZE         = 8;
    localparam int OUTPUT_CHANNELS = 10;

    localparam int N       = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS;
    localparam int BEAT_W  = $clog2(N);
    localparam int CLASS_W = $clog2(OUTPUT_CHANNELS);

    typedef logic signed [PX_SIZE-1:0] score_t;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SCAN,
        ST_HOLD
    } state_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mnet_frame_loader_argmax_scan.sv
// Sequential arg-max over a captured score vector, one signed compare per cycle.
// Only a strictly greater score replaces the best, so ties keep the lowest index.
module argmax_scan #(
    parameter int N_SCORES = 10,
    parameter int W        = 8,
    parameter int IW       = mnet_pkg::clog2_min1(N_SCORES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_SCORES-1:0][W-1:0] scores,
    output logic                       done,
    output logic [IW-1:0]              index,
    output logic [W-1:0]               score
);

    logic                busy;
    logic [IW-1:0]       pos;
    logic signed [W-1:0] cand;
    logic signed [W-1:0] best;
    logic                take;

    assign cand = scores[pos];
    assign best = score;
    assign take = (pos == '0) || (cand > best);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            pos   <= '0;
            done  <= 1'b0;
            index <= '0;
            score <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                pos  <= '0;
            end else if (busy) begin
                if (take) begin
                    score <= cand;
                    index <= pos;
                end
                if (pos == IW'(N_SCORES - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    pos <= pos + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mnet_frame_loader.sv
// Streaming pixel loader and arg-max result stage around the mini-MobileNet core.
// Beats fill the frame buffer; scores are captured after a settle window and scanned.
module mnet_frame_loader #(
    parameter int INPUT_SIZE      = mnet_pkg::INPUT_SIZE,
    parameter int INPUT_CHANNELS  = mnet_pkg::INPUT_CHANNELS,
    parameter int PX_SIZE         = mnet_pkg::PX_SIZE,
    parameter int OUTPUT_CHANNELS = mnet_pkg::OUTPUT_CHANNELS,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [PX_SIZE-1:0]                 s_data,
    input  logic                               s_last,
    output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] frame_out,
    input  logic [OUTPUT_CHANNELS-1:0][PX_SIZE-1:0] scores_in,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [$clog2(OUTPUT_CHANNELS)-1:0] m_class,
    output logic [PX_SIZE-1:0]                 m_score,
    output logic                               err_len
);
    import mnet_pkg::*;

    localparam int FRAME_BEATS = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS;
    localparam int BW          = clog2_min1(FRAME_BEATS);
    localparam int SW          = clog2_min1(SETTLE_CYCLES);
    localparam int CW          = $clog2(OUTPUT_CHANNELS);

    state_t                                   state;
    logic [BW-1:0]                            beat;
    logic [SW-1:0]                            settle;
    logic [FRAME_BEATS*PX_SIZE-1:0]           frame;
    logic [OUTPUT_CHANNELS-1:0][PX_SIZE-1:0]  scores_q;
    logic                                     accept;
    logic                                     last_beat;
    logic                                     scan_done;
    logic [CW-1:0]                            scan_index;
    logic [PX_SIZE-1:0]                       scan_score;

    // Beat k lands at flat element k, which is (row, col, channel) in the packed frame.
    assign frame_out = frame;
    assign s_ready   = (state == ST_LOAD) && !rst;
    assign accept    = s_valid && s_ready;
    assign last_beat = (beat == BW'(FRAME_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_LOAD;
            beat     <= '0;
            settle   <= '0;
            frame    <= '0;
            scores_q <= '0;
            m_valid  <= 1'b0;
            m_class  <= '0;
            m_score  <= '0;
            err_len  <= 1'b0;
        end else begin
            err_len <= 1'b0;
            unique case (state)
                ST_LOAD: begin
                    if (accept) begin
                        frame[beat*PX_SIZE +: PX_SIZE] <= s_data;
                        if (last_beat) begin
                            beat    <= '0;
                            err_len <= !s_last;
                            state   <= ST_SETTLE;
                        end else if (s_last) begin
                            beat    <= '0;
                            err_len <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle == SW'(SETTLE_CYCLES - 1)) begin
                        settle <= '0;
                        state  <= ST_CAPTURE;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    scores_q <= scores_in;
                    state    <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (scan_done) begin
                        state   <= ST_HOLD;
                        m_valid <= 1'b1;
                        m_class <= scan_index;
                        m_score <= scan_score;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // The scanner starts on the capture edge and reads the registered scores afterwards.
    argmax_scan #(
        .N_SCORES (OUTPUT_CHANNELS),
        .W        (PX_SIZE),
        .IW       (CW)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .start  (state == ST_CAPTURE),
        .scores (scores_q),
        .done   (scan_done),
        .index  (scan_index),
        .score  (scan_score)
    );

endmodule
